// File: rtl/reset_controller.sv
// Reset sequencer: power-on, debounced key, software and watchdog sources drive a timed RST_OUT_N pulse.
// Define RESET_CONTROLLER_WDT_EN to build the watchdog (KICK, CAUSE=11); otherwise KICK is ignored.
module reset_controller #(
    parameter int PULSE_CYCLES    = 1000,
    parameter int HOLDOFF_CYCLES  = 1000,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int WDT_CYCLES      = 100000000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       KEY_N,
    input  logic       SW_REQ,
    input  logic       KICK,
    output logic       RST_OUT_N,
    output logic       BUSY,
    output logic [1:0] CAUSE
);

    typedef enum logic [1:0] {
        ST_PULSE   = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_KEY = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;
    localparam logic [1:0] CAUSE_WDT = 2'b11;

    localparam int CNT_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_TOP = DEB_W'(DEBOUNCE_CYCLES);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             rst_out_n_reg;
    logic             busy_reg;
    logic [1:0]       cause_reg;

    logic             key_meta_reg;
    logic             key_sync_reg;
    logic [DEB_W-1:0] deb_cnt_reg;
    logic             key_armed_reg;
    logic             key_event;
    logic             wdt_event;

    logic             req_any;
    logic [1:0]       req_cause;

    // Key path: two-flop synchronizer, then a saturating low-level debounce counter.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            key_meta_reg <= 1'b1;
            key_sync_reg <= 1'b1;
        end else begin
            key_meta_reg <= KEY_N;
            key_sync_reg <= key_meta_reg;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            deb_cnt_reg <= '0;
        end else if (key_sync_reg) begin
            deb_cnt_reg <= '0;
        end else if (deb_cnt_reg != DEB_TOP) begin
            deb_cnt_reg <= deb_cnt_reg + 1'b1;
        end
    end

    // One event per press: disarm on firing whatever the state, re-arm only after a released sample.
    assign key_event = key_armed_reg && (deb_cnt_reg == DEB_TOP);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            key_armed_reg <= 1'b1;
        end else if (key_sync_reg) begin
            key_armed_reg <= 1'b1;
        end else if (key_event) begin
            key_armed_reg <= 1'b0;
        end
    end

`ifdef RESET_CONTROLLER_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt_reg;

    // Held at zero outside RUN so every RUN entry starts a fresh timeout window.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wdt_cnt_reg <= '0;
        end else if ((state_reg != ST_RUN) || KICK) begin
            wdt_cnt_reg <= '0;
        end else if (wdt_cnt_reg != WDT_LAST) begin
            wdt_cnt_reg <= wdt_cnt_reg + 1'b1;
        end
    end

    assign wdt_event = (state_reg == ST_RUN) && (wdt_cnt_reg == WDT_LAST) && !KICK;
`else
    logic unused_wdt;
    assign unused_wdt = KICK ^ (WDT_CYCLES > 1);
    assign wdt_event  = 1'b0;
`endif

    always_comb begin
        req_any   = 1'b1;
        req_cause = CAUSE_KEY;
        if (key_event) begin
            req_cause = CAUSE_KEY;
        end else if (wdt_event) begin
            req_cause = CAUSE_WDT;
        end else if (SW_REQ) begin
            req_cause = CAUSE_SW;
        end else begin
            req_any = 1'b0;
        end
    end

    assign cnt_next = (cnt_reg == CNT_TOP) ? cnt_reg : cnt_reg + 1'b1;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg     <= ST_PULSE;
            cnt_reg       <= '0;
            rst_out_n_reg <= 1'b0;
            busy_reg      <= 1'b1;
            cause_reg     <= CAUSE_POR;
        end else begin
            case (state_reg)
                ST_PULSE: begin
                    if (cnt_reg >= PULSE_LAST) begin
                        state_reg     <= ST_HOLDOFF;
                        cnt_reg       <= '0;
                        rst_out_n_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt_reg >= HOLD_LAST) begin
                        state_reg <= ST_RUN;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
                ST_RUN: begin
                    if (req_any) begin
                        state_reg     <= ST_PULSE;
                        cnt_reg       <= '0;
                        rst_out_n_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        cause_reg     <= req_cause;
                    end
                end
                default: begin
                    state_reg     <= ST_PULSE;
                    cnt_reg       <= '0;
                    rst_out_n_reg <= 1'b0;
                    busy_reg      <= 1'b1;
                end
            endcase
        end
    end

    assign RST_OUT_N = rst_out_n_reg;
    assign BUSY      = busy_reg;
    assign CAUSE     = cause_reg;

endmodule

// File: tb/tb_reset_controller.sv
// Directed bench for reset_controller with PULSE=4, HOLDOFF=2, DEBOUNCE=3, WDT=10.
// Watchdog scenarios are selected by RESET_CONTROLLER_WDT_EN.
module tb_reset_controller;

    logic       CLK;
    logic       RESET_N;
    logic       KEY_N;
    logic       SW_REQ;
    logic       KICK;
    logic       RST_OUT_N;
    logic       BUSY;
    logic [1:0] CAUSE;

    int total;
    int bad;

    reset_controller #(
        .PULSE_CYCLES    (4),
        .HOLDOFF_CYCLES  (2),
        .DEBOUNCE_CYCLES (3),
        .WDT_CYCLES      (10)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .KEY_N     (KEY_N),
        .SW_REQ    (SW_REQ),
        .KICK      (KICK),
        .RST_OUT_N (RST_OUT_N),
        .BUSY      (BUSY),
        .CAUSE     (CAUSE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        int lows;
        RESET_N = 1'b0;
        KEY_N   = 1'b1;
        SW_REQ  = 1'b0;
        KICK    = 1'b1;
        repeat (3) tick();
        total++; if (RST_OUT_N !== 1'b0) begin bad++; $display("FAIL reset_rst got=%b want=0", RST_OUT_N); end
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", BUSY); end
        total++; if (CAUSE !== 2'b00) begin bad++; $display("FAIL reset_cause got=%b want=00", CAUSE); end
        RESET_N = 1'b1;
        lows = 0;
        repeat (3) begin tick(); if (RST_OUT_N === 1'b0) lows++; end
        total++; if (lows != 3) begin bad++; $display("FAIL por_pulse_low got=%0d want=3", lows); end
        tick();
        total++; if (RST_OUT_N !== 1'b1) begin bad++; $display("FAIL por_pulse_end got=%b want=1", RST_OUT_N); end
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL por_holdoff1 got=%b want=1", BUSY); end
        tick();
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL por_holdoff2 got=%b want=1", BUSY); end
        tick();
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL por_run_busy got=%b want=0", BUSY); end
        total++; if (CAUSE !== 2'b00) begin bad++; $display("FAIL por_cause got=%b want=00", CAUSE); end
        $display("test_reset: power-on sequence checked");
    endtask

    task automatic test_sw();
        int lows;
        SW_REQ = 1'b1; tick(); SW_REQ = 1'b0;
        total++; if (RST_OUT_N !== 1'b0) begin bad++; $display("FAIL sw_pulse_start got=%b want=0", RST_OUT_N); end
        total++; if (CAUSE !== 2'b10) begin bad++; $display("FAIL sw_cause got=%b want=10", CAUSE); end
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL sw_busy got=%b want=1", BUSY); end
        lows = 1;
        // Extra requests land in PULSE (edge 2) and HOLDOFF (edge 5) and must be dropped.
        for (int i = 1; i <= 6; i++) begin
            SW_REQ = (i == 2 || i == 5);
            tick();
            SW_REQ = 1'b0;
            if (RST_OUT_N === 1'b0) lows++;
        end
        total++; if (lows != 4) begin bad++; $display("FAIL sw_pulse_len got=%0d want=4", lows); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL sw_back_in_run got=%b want=0", BUSY); end
        lows = 0;
        repeat (6) begin tick(); if (RST_OUT_N === 1'b0) lows++; end
        total++; if (lows != 0) begin bad++; $display("FAIL sw_dropped_req got=%0d want=0", lows); end
        $display("test_sw: software request and holdoff drop checked");
    endtask

    task automatic test_key();
        int  lows;
        int  falls;
        logic prev;
        lows = 0;
        repeat (3) begin
            KEY_N = 1'b0; repeat (2) begin tick(); if (RST_OUT_N === 1'b0) lows++; end
            KEY_N = 1'b1; repeat (2) begin tick(); if (RST_OUT_N === 1'b0) lows++; end
        end
        repeat (2) begin tick(); if (RST_OUT_N === 1'b0) lows++; end
        total++; if (lows != 0) begin bad++; $display("FAIL key_bounce got=%0d want=0", lows); end
        KEY_N = 1'b0;
        falls = 0; lows = 0; prev = RST_OUT_N;
        repeat (20) begin
            tick();
            if (RST_OUT_N === 1'b0) lows++;
            if (prev === 1'b1 && RST_OUT_N === 1'b0) falls++;
            prev = RST_OUT_N;
        end
        total++; if (falls != 1) begin bad++; $display("FAIL key_held_pulses got=%0d want=1", falls); end
        total++; if (lows != 4) begin bad++; $display("FAIL key_pulse_len got=%0d want=4", lows); end
        total++; if (CAUSE !== 2'b01) begin bad++; $display("FAIL key_cause got=%b want=01", CAUSE); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL key_run got=%b want=0", BUSY); end
        KEY_N = 1'b1;
        repeat (4) tick();
        KEY_N = 1'b0;
        falls = 0; prev = RST_OUT_N;
        repeat (12) begin
            tick();
            if (prev === 1'b1 && RST_OUT_N === 1'b0) falls++;
            prev = RST_OUT_N;
        end
        total++; if (falls != 1) begin bad++; $display("FAIL key_second_press got=%0d want=1", falls); end
        KEY_N = 1'b1;
        repeat (4) tick();
        $display("test_key: debounce and single event per press checked");
    endtask

    task automatic test_priority();
        KICK = 1'b0;
        SW_REQ = 1'b1; tick(); SW_REQ = 1'b0;
        total++; if (CAUSE !== 2'b10) begin bad++; $display("FAIL prio_setup_cause got=%b want=10", CAUSE); end
        repeat (6) tick();
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL prio_run got=%b want=0", BUSY); end
        repeat (4) tick();
        // Key goes low here so its event, the watchdog terminal count and SW_REQ meet on RUN cycle 10.
        KEY_N = 1'b0;
        repeat (5) tick();
        total++; if (RST_OUT_N !== 1'b1) begin bad++; $display("FAIL prio_early got=%b want=1", RST_OUT_N); end
        SW_REQ = 1'b1; tick(); SW_REQ = 1'b0;
        KICK = 1'b1;
        total++; if (RST_OUT_N !== 1'b0) begin bad++; $display("FAIL prio_pulse got=%b want=0", RST_OUT_N); end
        total++; if (CAUSE !== 2'b01) begin bad++; $display("FAIL prio_cause got=%b want=01", CAUSE); end
        KEY_N = 1'b1;
        repeat (8) tick();
        $display("test_priority: simultaneous events checked");
    endtask

`ifdef RESET_CONTROLLER_WDT_EN
    task automatic test_watchdog();
        int lows;
        KICK = 1'b0;
        SW_REQ = 1'b1; tick(); SW_REQ = 1'b0;
        repeat (6) tick();
        lows = 0;
        repeat (9) begin tick(); if (RST_OUT_N === 1'b0) lows++; end
        total++; if (lows != 0) begin bad++; $display("FAIL wdt_early got=%0d want=0", lows); end
        tick();
        total++; if (RST_OUT_N !== 1'b0) begin bad++; $display("FAIL wdt_timeout got=%b want=0", RST_OUT_N); end
        total++; if (CAUSE !== 2'b11) begin bad++; $display("FAIL wdt_cause got=%b want=11", CAUSE); end
        repeat (6) tick();
        lows = 0;
        for (int i = 0; i < 36; i++) begin
            KICK = ((i % 9) == 8);
            tick();
            if (RST_OUT_N === 1'b0) lows++;
        end
        KICK = 1'b0;
        total++; if (lows != 0) begin bad++; $display("FAIL wdt_kick9 got=%0d want=0", lows); end
        lows = 0;
        repeat (9) begin tick(); if (RST_OUT_N === 1'b0) lows++; end
        KICK = 1'b1; tick(); KICK = 1'b0;
        if (RST_OUT_N === 1'b0) lows++;
        total++; if (lows != 0) begin bad++; $display("FAIL wdt_kick_terminal got=%0d want=0", lows); end
        lows = 0;
        repeat (9) begin tick(); if (RST_OUT_N === 1'b0) lows++; end
        SW_REQ = 1'b1; tick(); SW_REQ = 1'b0;
        total++; if (lows != 0) begin bad++; $display("FAIL wdt_rewindow got=%0d want=0", lows); end
        total++; if (RST_OUT_N !== 1'b0) begin bad++; $display("FAIL wdt_vs_sw_pulse got=%b want=0", RST_OUT_N); end
        total++; if (CAUSE !== 2'b11) begin bad++; $display("FAIL wdt_vs_sw_cause got=%b want=11", CAUSE); end
        KICK = 1'b1;
        repeat (6) tick();
        $display("test_watchdog: timeout, kick and terminal kick checked");
    endtask
`else
    task automatic test_watchdog();
        int lows;
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            KICK = i[0];
            tick();
            if (RST_OUT_N === 1'b0) lows++;
        end
        KICK = 1'b0;
        repeat (20) begin tick(); if (RST_OUT_N === 1'b0) lows++; end
        KICK = 1'b1;
        total++; if (lows != 0) begin bad++; $display("FAIL nowdt_pulse got=%0d want=0", lows); end
        total++; if (CAUSE !== 2'b01) begin bad++; $display("FAIL nowdt_cause got=%b want=01", CAUSE); end
        $display("test_watchdog: watchdog absent, KICK ignored");
    endtask
`endif

    task automatic test_reset_mid_pulse();
        int lows;
        SW_REQ = 1'b1; tick(); SW_REQ = 1'b0;
        repeat (2) tick();
        RESET_N = 1'b0;
        #1;
        total++; if (RST_OUT_N !== 1'b0) begin bad++; $display("FAIL mid_rst got=%b want=0", RST_OUT_N); end
        total++; if (CAUSE !== 2'b00) begin bad++; $display("FAIL mid_cause got=%b want=00", CAUSE); end
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", BUSY); end
        repeat (2) tick();
        RESET_N = 1'b1;
        lows = 0;
        repeat (3) begin tick(); if (RST_OUT_N === 1'b0) lows++; end
        total++; if (lows != 3) begin bad++; $display("FAIL mid_full_pulse got=%0d want=3", lows); end
        tick();
        total++; if (RST_OUT_N !== 1'b1) begin bad++; $display("FAIL mid_pulse_end got=%b want=1", RST_OUT_N); end
        repeat (2) tick();
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL mid_run got=%b want=0", BUSY); end
        $display("test_reset_mid_pulse: abort and restart checked");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_sw();
        test_key();
        test_priority();
        test_watchdog();
        test_reset_mid_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reset_controller.md
RESET_CONTROLLER -- requirements
Module: reset_controller

Interface
REQ-001 Parameter PULSE_CYCLES, default 1000: RST_OUT_N low-time per reset event, in CLK cycles (≥1).
REQ-002 Parameter HOLDOFF_CYCLES, default 1000: cycles after a pulse during which new requests are ignored (≥1).
REQ-003 Parameter DEBOUNCE_CYCLES, default 50000: consecutive synchronized-low cycles on KEY_N that count as one press (≥1).
REQ-004 Parameter WDT_CYCLES, default 100000000: watchdog timeout in cycles without KICK (≥2).
REQ-005 CLK  input  1  system clock; all state changes on its rising edge.
REQ-006 RESET_N  input  1  asynchronous, active-low reset.
REQ-007 KEY_N  input  1  asynchronous push-button, active low, bouncing.
REQ-008 SW_REQ  input  1  synchronous single-cycle software reset request.
REQ-009 KICK  input  1  synchronous watchdog service strobe.
REQ-010 RST_OUT_N  output  1  registered downstream reset, active low, deasserted synchronously to CLK.
REQ-011 BUSY  output  1  high in any state other than RUN.
REQ-012 CAUSE  output  2  cause of the last pulse: 00 power-on, 01 key, 10 software, 11 watchdog.

Function
REQ-013 States SHALL be PULSE, HOLDOFF and RUN; one cycle counter SHALL be shared by PULSE and HOLDOFF, sized for the larger of the two parameters.
REQ-014 PULSE: RST_OUT_N=0; after PULSE_CYCLES cycles in PULSE -> HOLDOFF, and RST_OUT_N SHALL be 1 on the first HOLDOFF cycle.
REQ-015 HOLDOFF: RST_OUT_N=1; after HOLDOFF_CYCLES cycles -> RUN; all requests arriving in PULSE or HOLDOFF SHALL be dropped, not queued.
REQ-016 RUN: an event sampled at edge N SHALL cause PULSE, with RST_OUT_N=0, from edge N+1 for exactly PULSE_CYCLES cycles, and CAUSE updated on that same edge.
REQ-017 Simultaneous events SHALL be resolved by priority key > watchdog > software; only the winner's code SHALL be recorded in CAUSE.
REQ-018 KEY_N SHALL pass a 2-flop synchronizer; the debounce counter SHALL count while the synchronized level is low and clear when it is high.
REQ-019 The key event SHALL fire once, when the debounce count reaches DEBOUNCE_CYCLES; no further key event SHALL fire until KEY_N has been seen high for one synchronized cycle.
REQ-020 A press held across PULSE/HOLDOFF SHALL NOT produce a second event on entering RUN.
REQ-021 The watchdog counter SHALL count only in RUN, SHALL clear on entering RUN and on KICK, and SHALL produce an event when it reaches WDT_CYCLES-1 without KICK.
REQ-022 If KICK and the terminal count coincide, KICK SHALL win and no event SHALL fire.
REQ-023 All counters SHALL saturate and never wrap.

Reset
REQ-024 While RESET_N=0: state=PULSE, counters=0, RST_OUT_N=0, BUSY=1, CAUSE=00, synchronizer flops=1.
REQ-025 After RESET_N rises, the PULSE count SHALL start on the first CLK edge, giving a full PULSE_CYCLES low period, then HOLDOFF and RUN as normal.
REQ-026 RESET_N asserted mid-operation SHALL abort any state immediately and restart the sequence of REQ-024.

Configuration
REQ-027 Macro RESET_CONTROLLER_WDT_EN defined: watchdog counter, KICK handling and CAUSE=11 SHALL be present as specified.
REQ-028 Macro RESET_CONTROLLER_WDT_EN undefined: no watchdog logic SHALL be built, KICK SHALL be ignored and CAUSE SHALL never be 11; the port list SHALL be unchanged.

Verification (PULSE=4, HOLDOFF=2, DEBOUNCE=3, WDT=10)
REQ-029 Release RESET_N -> RST_OUT_N low for 4 more edges, then BUSY high for 2 edges, then BUSY=0, CAUSE=00.
REQ-030 In RUN, SW_REQ for 1 cycle -> RST_OUT_N low on the next edge for 4 cycles, CAUSE=10; a second SW_REQ during HOLDOFF is dropped.
REQ-031 KEY_N bouncing with 2-cycle lows, then held low for 20 cycles -> exactly one pulse, CAUSE=01; no second pulse until KEY_N is released and pressed again.
REQ-032 With the macro defined and no KICK for 10 RUN cycles -> pulse with CAUSE=11; KICK every 9 cycles -> no pulse; KICK on the terminal cycle -> no pulse.
REQ-033 Key event, watchdog timeout and SW_REQ on the same cycle -> CAUSE=01; RESET_N pulsed low mid-PULSE -> RST_OUT_N stays 0 and a full 4-cycle PULSE follows the release.
